// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI4-Lite manager: turns local write/read commands into AW/W/B or AR/R traffic.
// Optional RESP_ERR_CNT_EN adds err_cnt, a saturating count of non-OKAY responses.
module axi_lite_initiator #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_done,
  output logic [1:0]            rsp_resp,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  busy,
`ifdef RESP_ERR_CNT_EN
  output logic [7:0]            err_cnt,
`endif
  output logic [ADDR_W-1:0]     AWADDR,
  output logic [2:0]            AWPROT,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_W-1:0]     WDATA,
  output logic [DATA_W/8-1:0]   WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_W-1:0]     ARADDR,
  output logic [2:0]            ARPROT,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_W-1:0]     RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {StIdle, StWrAwW, StWrB, StRdAr, StRdR} state_e;

  state_e                state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]     araddr_q, araddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  rsp_done_q, rsp_done_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_done_d  = 1'b0;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWrAwW;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = StRdAr;
          end
        end
      end
      StWrAwW: begin
        // AW and W retire independently; a channel already done keeps its VALID low.
        awvalid_d = awvalid_q & ~AWREADY;
        wvalid_d  = wvalid_q & ~WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = StWrB;
        end
      end
      StWrB: begin
        if (BVALID) begin
          bready_d    = 1'b0;
          rsp_resp_d  = BRESP;
          rsp_rdata_d = '0;
          rsp_done_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      StRdAr: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdR;
        end
      end
      StRdR: begin
        if (RVALID) begin
          rready_d    = 1'b0;
          rsp_resp_d  = RRESP;
          rsp_rdata_d = RDATA;
          rsp_done_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (reset) begin
      state_q     <= StIdle;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_done_q  <= 1'b0;
      rsp_resp_q  <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_done_q  <= rsp_done_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef RESP_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge ACLK) begin
    if (reset) begin
      err_cnt_q <= 8'h00;
    end else if (rsp_done_d && (rsp_resp_d != 2'b00) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  assign rsp_done  = rsp_done_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_rdata = rsp_rdata_q;
  assign AWADDR    = awaddr_q;
  assign AWPROT    = 3'b000;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARADDR    = araddr_q;
  assign ARPROT    = 3'b000;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;

endmodule
